apb_uart_tx_slave: RTL and testbench

//  APB completer that sits downstream of the APB master on one PSELx line.

---
 rtl/apb_uart_tx_slave_if.sv | 22 ++
 rtl/apb_uart_tx_slave.sv | 168 ++++++++++++++++
 tb/tb_apb_uart_tx_slave.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_tx_slave_if.sv
// APB completer bus bundle for apb_uart_tx_slave.
// Signals: PSEL, PENABLE, PWRITE, PWDATA[m] from master; PREADY, PRDATA to master.
interface apb_uart_tx_slave_if #(
   parameter int m = 8
);
   logic         PSEL;
   logic         PENABLE;
   logic         PWRITE;
   logic [m-1:0] PWDATA;
   logic         PREADY;
   logic         PRDATA;

   modport master (
      output PSEL, PENABLE, PWRITE, PWDATA,
      input  PREADY, PRDATA
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PWDATA,
      output PREADY, PRDATA
   );
endinterface

// File: rtl/apb_uart_tx_slave.sv
// APB write -> FIFO -> UART TX (LSB first). PREADY stalls writes while full.
// Ports: PCLK, PRESET (async, active-low), apb (slave modport: PSEL/PENABLE/
// PWRITE/PWDATA in, PREADY/PRDATA out), o_tx, o_tx_busy, o_fifo_full.
// Define APB_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module apb_uart_tx_slave #(
   parameter int m            = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   apb_uart_tx_slave_if.slave     apb,
   output logic                   o_tx,
   output logic                   o_tx_busy,
   output logic                   o_fifo_full
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int NW = (m > 1) ? $clog2(m) : 1;

`ifdef APB_UART_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   logic [m-1:0]  mem [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q, count_d;
   state_t        state_q;
   logic [BW-1:0] baud_q;
   logic [NW-1:0] bit_q;
   logic [m-1:0]  sh_q;
   logic          tx_q;
`ifdef APB_UART_PARITY_EN
   logic          par_q;
`endif

   logic full, has_data, baud_last, push, pop;

   // Full comes from the registered count, so a pop never
   // frees a slot for a push in the same cycle.
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign has_data  = (count_q != '0);
   assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

   assign apb.PREADY = apb.PSEL & apb.PENABLE & (~apb.PWRITE | ~full);
   assign push       = apb.PSEL & apb.PENABLE & apb.PWRITE & apb.PREADY;
   assign o_tx_busy  = has_data | (state_q != S_IDLE);
   assign apb.PRDATA = apb.PSEL & apb.PENABLE & ~apb.PWRITE & o_tx_busy;
   assign o_fifo_full = full;
   assign o_tx        = tx_q;

   // Pop whenever the FSM loads a new frame.
   assign pop = has_data &
                ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_last));

   always_comb begin
      count_d = count_q;
      unique case (1'b1)
         (push & ~pop): count_d = count_q + CW'(1);
         (pop & ~push): count_d = count_q - CW'(1);
         default:       count_d = count_q;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (push) mem[wr_q] <= apb.PWDATA;
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (push) wr_q <= wr_q + PW'(1);
         if (pop)  rd_q <= rd_q + PW'(1);
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
`ifdef APB_UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         baud_q <= baud_last ? '0 : baud_q + BW'(1);
         unique case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               tx_q   <= 1'b1;
               if (has_data) begin
                  sh_q    <= mem[rd_q];
`ifdef APB_UART_PARITY_EN
                  par_q   <= ^mem[rd_q];
`endif
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_last) begin
                  bit_q   <= '0;
                  tx_q    <= sh_q[0];
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (baud_last) begin
                  if (bit_q == NW'(m - 1)) begin
`ifdef APB_UART_PARITY_EN
                     tx_q    <= par_q;
                     state_q <= S_PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
`endif
                  end else begin
                     bit_q <= bit_q + NW'(1);
                     sh_q  <= sh_q >> 1;
                     tx_q  <= sh_q[1];
                  end
               end
            end
`ifdef APB_UART_PARITY_EN
            S_PARITY: begin
               if (baud_last) begin
                  tx_q    <= 1'b1;
                  state_q <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (baud_last) begin
                  // Back-to-back frames: reload straight into START.
                  if (has_data) begin
                     sh_q    <= mem[rd_q];
`ifdef APB_UART_PARITY_EN
                     par_q   <= ^mem[rd_q];
`endif
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_uart_tx_slave.sv
// Randomized bench for apb_uart_tx_slave; a frame-level
// receiver model decodes o_tx and tracks FIFO occupancy.
module tb_apb_uart_tx_slave;
   localparam int M     = 8;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;
`ifdef APB_UART_PARITY_EN
   localparam int NB = M + 3;
`else
   localparam int NB = M + 2;
`endif

   logic PCLK = 1'b0;
   logic PRESET = 1'b0;
   logic o_tx, o_tx_busy, o_fifo_full;

   always #5 PCLK = ~PCLK;

   apb_uart_tx_slave_if #(.m(M)) apb ();

   apb_uart_tx_slave #(
      .m(M), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
   ) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .apb(apb),
      .o_tx(o_tx),
      .o_tx_busy(o_tx_busy),
      .o_fifo_full(o_fifo_full)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [M-1:0] exp_q [$];
   int           pushed, started, k, stall_cnt;
   bit           active, xfer_done;
   logic         bits [NB];
   logic [M-1:0] cur_byte, last_byte;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int occ();
      return pushed - started;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      pushed = 0;
      started = 0;
      active = 0;
      k = 0;
   endtask

   // One PCLK cycle: check APB outputs mid-cycle, then step the model
   // and check the line/status right after the edge.
   task automatic tick();
      bit do_push;
      logic [M-1:0] wd;
      int cb;
      logic [M-1:0] got;
      @(negedge PCLK);
      cb = occ();
      do_push = 0;
      xfer_done = 0;
      if (apb.PSEL && apb.PENABLE) begin
         if (apb.PWRITE) begin
            check("pready_wr", 32'(apb.PREADY), 32'(cb != DEPTH));
            do_push = (cb != DEPTH);
            xfer_done = do_push;
            if (!do_push) stall_cnt++;
         end else begin
            check("pready_rd", 32'(apb.PREADY), 32'd1);
            check("prdata", 32'(apb.PRDATA), 32'(active || cb > 0));
            xfer_done = 1;
         end
      end else begin
         check("pready_idle", 32'(apb.PREADY), 32'd0);
         check("prdata_idle", 32'(apb.PRDATA), 32'd0);
      end
      wd = apb.PWDATA;
      @(posedge PCLK);
      #1;
      if (do_push) begin
         pushed++;
         exp_q.push_back(wd);
      end
      if (!active || k == NB * CPB - 1) begin
         if (cb > 0) begin
            check("start", 32'(o_tx), 32'd0);
            active = 1;
            k = 0;
            bits[0] = 1'b0;
            started++;
            cur_byte = exp_q.pop_front();
         end else begin
            check("idle_tx", 32'(o_tx), 32'd1);
            active = 0;
         end
      end else begin
         k++;
         if (k % CPB == 0) bits[k / CPB] = o_tx;
         else check("bit_hold", 32'(o_tx), 32'(bits[k / CPB]));
         if (k == (NB - 1) * CPB) begin
            for (int i = 0; i < M; i++) got[i] = bits[i + 1];
            check("data", 32'(got), 32'(cur_byte));
            check("stop", 32'(bits[NB - 1]), 32'd1);
`ifdef APB_UART_PARITY_EN
            check("parity", 32'(bits[M + 1]), 32'(^cur_byte));
`endif
            last_byte = got;
         end
      end
      check("busy", 32'(o_tx_busy), 32'(active || occ() > 0));
      check("full", 32'(o_fifo_full), 32'(occ() == DEPTH));
   endtask

   task automatic apb_write(input logic [M-1:0] d);
      bit done;
      done = 0;
      apb.PSEL = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE = 1'b1;
      apb.PWDATA = d;
      tick();
      apb.PENABLE = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         tick();
         done = xfer_done;
      end
      if (!done) check("wr_timeout", 32'd0, 32'd1);
      apb.PSEL = 1'b0;
      apb.PENABLE = 1'b0;
   endtask

   task automatic apb_read();
      apb.PSEL = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE = 1'b0;
      tick();
      apb.PENABLE = 1'b1;
      tick();
      apb.PSEL = 1'b0;
      apb.PENABLE = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && (active || occ() > 0); i++) tick();
      check("drain", 32'(active || occ() > 0), 32'd0);
   endtask

   initial begin
      apb.PSEL = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE = 1'b0;
      apb.PWDATA = '0;
      stall_cnt = 0;
      last_byte = '0;
      cur_byte = '0;
      model_reset();

      repeat (2) @(posedge PCLK);
      #1;
      check("rst_tx", 32'(o_tx), 32'd1);
      check("rst_busy", 32'(o_tx_busy), 32'd0);
      check("rst_full", 32'(o_fifo_full), 32'd0);
      check("rst_pready", 32'(apb.PREADY), 32'd0);
      @(negedge PCLK);
      PRESET = 1'b1;

      apb_write(8'hA5);
      drain();
      check("a5_byte", 32'(last_byte), 32'h0000_00A5);
      apb_read();

      for (int i = 1; i <= 6; i++) begin
         apb_write(M'(i));
         if (i == 3) apb_read();
      end
      check("stall_seen", 32'(stall_cnt > 0), 32'd1);
      drain();
      check("burst_last", 32'(last_byte), 32'd6);

      for (int n = 0; n < 80; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 6) apb_write(M'($urandom));
         else if (r < 8) apb_read();
         else repeat ($urandom_range(1, 30)) tick();
      end
      drain();

      for (int i = 0; i < 5; i++) apb_write(M'(8'h10 + i));
      repeat (6) tick();
      check("pre_rst_full", 32'(o_fifo_full), 32'(occ() == DEPTH));
      @(negedge PCLK);
      #1;
      PRESET = 1'b0;
      #1;
      check("arst_tx", 32'(o_tx), 32'd1);
      check("arst_busy", 32'(o_tx_busy), 32'd0);
      check("arst_full", 32'(o_fifo_full), 32'd0);
      model_reset();
      repeat (2) tick();
      PRESET = 1'b1;
      apb_write(8'h3C);
      drain();
      check("post_rst", 32'(last_byte), 32'h0000_003C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
